// File: rtl/pipe_scheduler_if.sv
// Bus between the game-state control, the pipe scheduler and the row-register bank.
// The control side (master) drives enable/freeze. The scheduler (slave) returns the
// shift strobe, the column bits, the gap position and the pipe count.
interface pipe_scheduler_if #(
  parameter int ROWS = 16
);
  logic            enable;
  logic            freeze;
  logic            shift_sel;
  logic [ROWS-1:0] col_data;
  logic [3:0]      gap_top;
  logic [7:0]      pipe_count;

  modport master (
    output enable,
    output freeze,
    input  shift_sel,
    input  col_data,
    input  gap_top,
    input  pipe_count
  );

  modport slave (
    input  enable,
    input  freeze,
    output shift_sel,
    output col_data,
    output gap_top,
    output pipe_count
  );
endinterface

// File: rtl/pipe_scheduler.sv
// Pipe field scheduler for the scrolling LED array.
// A free-running divider produces one shift strobe every 2^TICK_LOG2 clocks.
// Each strobe carries one column for all row registers: PIPE_SPACING empty columns,
// then PIPE_WIDTH pipe columns with a GAP-row opening. The gap position comes from
// an 8-bit LFSR that advances once per strobe. All outputs are registered, so the
// column is already valid on the edge where the row registers see sel high.
module pipe_scheduler #(
  parameter int         ROWS         = 16,
  parameter int         TICK_LOG2    = 10,
  parameter int         PIPE_WIDTH   = 2,
  parameter int         PIPE_SPACING = 6,
  parameter int         GAP          = 4,
  parameter logic [7:0] SEED         = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  pipe_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SPACE, S_PIPE} state_t;

  localparam int COL_MAX = (PIPE_SPACING > PIPE_WIDTH) ? PIPE_SPACING : PIPE_WIDTH;
  localparam int CW      = (COL_MAX > 1) ? $clog2(COL_MAX) : 1;

  // The gap start is drawn from 1..ROWS-GAP-1.
  // This leaves at least one solid row above and below the opening.
  localparam logic [4:0]      GAP_MOD  = 5'(ROWS - GAP - 1);
  localparam logic [ROWS-1:0] GAP_MASK = {{(ROWS-GAP){1'b0}}, {GAP{1'b1}}};

  state_t              r_state;
  logic [TICK_LOG2-1:0] r_tick;
  logic [CW-1:0]       r_col;
  logic [7:0]          r_lfsr;
  logic [3:0]          r_gap;
  logic [7:0]          r_count;
  logic                r_sel;
  logic [ROWS-1:0]     r_data;

  logic                w_tick;
  logic                w_fb;
  logic [3:0]          w_gap_next;
  logic [ROWS-1:0]     w_pipe_col;
  logic                w_last_space;
  logic                w_last_pipe;

  assign w_tick       = (r_tick == {TICK_LOG2{1'b1}});
  // Fibonacci feedback for x^8+x^6+x^5+x^4+1.
  assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_gap_next   = 4'(({1'b0, r_lfsr[3:0]} % GAP_MOD) + 5'd1);
  assign w_pipe_col   = ~(GAP_MASK << r_gap);
  assign w_last_space = (r_col == CW'(PIPE_SPACING - 1));
  assign w_last_pipe  = (r_col == CW'(PIPE_WIDTH - 1));

  // Control FSM, tick divider, LFSR and all registered outputs.
  // Priority is: reset, then enable low (back to idle), then freeze (hold), then run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_col   <= '0;
      r_lfsr  <= SEED;
      r_gap   <= 4'd1;
      r_count <= 8'd0;
      r_sel   <= 1'b0;
      r_data  <= '0;
    end else if (!bus.enable) begin
      // LFSR, gap and pipe count deliberately survive a stop/restart.
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_col   <= '0;
      r_sel   <= 1'b0;
      r_data  <= '0;
    end else if (bus.freeze) begin
      r_sel <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_SPACE;
          r_col   <= '0;
          r_sel   <= 1'b0;
        end
        S_SPACE: begin
          r_tick <= r_tick + TICK_LOG2'(1);
          r_sel  <= w_tick;
          if (w_tick) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            r_data <= '0;
            if (w_last_space) begin
              r_state <= S_PIPE;
              r_col   <= '0;
              r_gap   <= w_gap_next;
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        S_PIPE: begin
          r_tick <= r_tick + TICK_LOG2'(1);
          r_sel  <= w_tick;
          if (w_tick) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            r_data <= w_pipe_col;
            if (w_last_pipe) begin
              r_state <= S_SPACE;
              r_col   <= '0;
              if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shift_sel  = r_sel;
  assign bus.col_data   = r_data;
  assign bus.gap_top    = r_gap;
  assign bus.pipe_count = r_count;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Randomized bench for pipe_scheduler with TICK_LOG2=2.
// The reference model counts active clocks since start.
// It derives ticks, column index and pipe shape from that count.
module tb_pipe_scheduler;

  localparam int ROWS    = 16;
  localparam int TL      = 2;
  localparam int PERIOD  = 1 << TL;
  localparam int SPACING = 6;
  localparam int WIDTH   = 2;
  localparam int GAPW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_scheduler_if #(.ROWS(ROWS)) bus ();

  pipe_scheduler #(
    .ROWS(ROWS), .TICK_LOG2(TL), .PIPE_WIDTH(WIDTH),
    .PIPE_SPACING(SPACING), .GAP(GAPW), .SEED(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_idle;
  int          m_active;   // counted clocks since leaving idle
  int          m_cols;     // columns emitted since leaving idle
  logic [7:0]  m_lfsr;
  int          m_gap;
  int          m_count;
  int          m_total;    // pipes emitted, unsaturated
  int          m_ticks;
  bit          m_sel;
  logic [15:0] m_col;
  bit          m_in_pipe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pipe_column(input int gap);
    logic [15:0] v;
    for (int i = 0; i < ROWS; i++) v[i] = !(i >= gap && i < gap + GAPW);
    return v;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic model_reset();
    m_idle = 1; m_active = 0; m_cols = 0; m_lfsr = 8'hA5; m_gap = 1;
    m_count = 0; m_sel = 0; m_col = '0; m_in_pipe = 0;
  endtask

  task automatic model_update();
    int j;
    if (!reset) begin
      model_reset();
    end else if (!bus.enable) begin
      m_idle = 1; m_active = 0; m_cols = 0; m_sel = 0; m_col = '0; m_in_pipe = 0;
    end else if (bus.freeze) begin
      m_sel = 0;
    end else if (m_idle) begin
      m_idle = 0; m_sel = 0;
    end else begin
      m_active++;
      m_sel = ((m_active % PERIOD) == 0);
      if (m_sel) begin
        j = m_cols % (SPACING + WIDTH);
        if (j < SPACING) begin
          m_col = '0;
          m_in_pipe = 0;
          if (j == SPACING - 1) m_gap = (m_lfsr[3:0] % (ROWS - GAPW - 1)) + 1;
        end else begin
          m_col = pipe_column(m_gap);
          m_in_pipe = 1;
          if (j == SPACING + WIDTH - 1) begin
            m_total++;
            if (m_count < 255) m_count++;
          end
        end
        m_lfsr = lfsr_next(m_lfsr);
        m_cols++;
        m_ticks++;
      end
    end
  endtask

  task automatic compare();
    chk("shift_sel", 32'(bus.shift_sel), 32'(m_sel));
    chk("col_data", 32'(bus.col_data), 32'(m_col));
    chk("gap_top", 32'(bus.gap_top), 32'(m_gap));
    chk("pipe_count", 32'(bus.pipe_count), 32'(m_count));
    if (m_sel) begin
      chk("gap_range", 32'(bus.gap_top >= 4'd1 && bus.gap_top <= 4'd11), 32'd1);
      if (m_in_pipe)
        chk("pipe_not_solid_or_empty",
            32'(bus.col_data != 16'hFFFF && bus.col_data != 16'h0000), 32'd1);
      $display("tick %0d col=%04h gap=%0d pipes=%0d", m_ticks, bus.col_data,
               bus.gap_top, bus.pipe_count);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic run_ticks(input int n);
    int target = m_ticks + n;
    int lim = 0;
    while (m_ticks < target && lim < 1000) begin
      cycle();
      lim++;
    end
    chk("tick_timeout", 32'(m_ticks >= target), 32'd1);
  endtask

  initial begin
    int n;
    bus.enable = 1'b0;
    bus.freeze = 1'b0;
    reset      = 1'b0;
    m_ticks    = 0;
    m_total    = 0;
    model_reset();

    // Reset state held for a few clocks.
    repeat (3) cycle();
    reset = 1'b1;
    repeat (2) cycle();

    // First sequence: 6 empty columns, 2 pipe columns, then spacing again.
    bus.enable = 1'b1;
    run_ticks(14);

    // Freeze for 10 clocks in the middle of a tick period.
    run_ticks(1);
    cycle();
    cycle();
    bus.freeze = 1'b1;
    repeat (10) cycle();
    bus.freeze = 1'b0;
    run_ticks(3);

    // Drop enable right after a pipe column, then restart.
    n = 0;
    while (!(m_in_pipe && m_sel) && n < 200) begin
      cycle();
      n++;
    end
    chk("reach_pipe", 32'(m_in_pipe), 32'd1);
    cycle();
    bus.enable = 1'b0;
    repeat (3) cycle();
    bus.enable = 1'b1;
    run_ticks(10);

    // Long randomized run until pipe_count saturates.
    n = 0;
    while (m_total < 300 && n < 40000) begin
      bus.freeze = ($urandom_range(0, 19) == 0);
      bus.enable = ($urandom_range(0, 799) != 0);
      cycle();
      n++;
    end
    chk("pipes_reached", 32'(m_total >= 300), 32'd1);
    chk("saturated", 32'(bus.pipe_count), 32'd255);
    bus.enable = 1'b1;
    bus.freeze = 1'b0;
    repeat (6) cycle();

    // Asynchronous reset in mid-run: outputs clear with no clock edge.
    reset = 1'b0;
    #2;
    chk("async_sel", 32'(bus.shift_sel), 32'd0);
    chk("async_col", 32'(bus.col_data), 32'd0);
    chk("async_gap", 32'(bus.gap_top), 32'd1);
    chk("async_count", 32'(bus.pipe_count), 32'd0);
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;
    run_ticks(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
